// File: rtl/dbg_run_ctrl.sv
// Debug/run sequencer between the host command channel and the pipelined core.
// Optional breakpoint support is compiled in with `define DBG_BREAKPOINT_EN.
module dbg_run_ctrl #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned STEP_CYC = 5,
    parameter logic [31:0] RUN_MAX  = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              cpu_ce,
    input  logic              cpu_stop,
    input  logic [31:0]       cpu_pc,
    output logic              inst_we,
    output logic              data_we,
    output logic              rf_dcp_rd,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [4:0]        rf_addr,
    output logic [31:0]       inst_in,
    output logic [31:0]       data_in,
    input  logic [31:0]       inst_out,
    input  logic [31:0]       data_out,
    input  logic [31:0]       rf_out
);

    localparam logic [2:0] OP_WR_INST = 3'd0;
    localparam logic [2:0] OP_WR_DATA = 3'd1;
    localparam logic [2:0] OP_RD_INST = 3'd2;
    localparam logic [2:0] OP_RD_DATA = 3'd3;
    localparam logic [2:0] OP_RD_RF   = 3'd4;
    localparam logic [2:0] OP_RUN     = 3'd5;
    localparam logic [2:0] OP_STEP    = 3'd6;
    localparam logic [2:0] OP_HALT    = 3'd7;
    localparam logic [31:0] ACK       = 32'h0000_0001;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RESP, S_RUN, S_STEP} state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic [31:0] cnt;
    logic        ce_en;
    logic        is_halt;
    logic        halt_acc;
    logic        wd_hit;
    logic        run_exit;
    logic        step_exit;
    logic [31:0] run_rsp;
    logic [31:0] step_rsp;

`ifdef DBG_BREAKPOINT_EN
    logic [31:0] bp;
    logic        bp_armed;
    logic        bp_hit;
    logic        is_setbp;

    assign is_halt  = (cmd_op == OP_HALT) && !cmd_addr[7];
    assign is_setbp = (cmd_op == OP_HALT) &&  cmd_addr[7];
    assign bp_hit   = bp_armed && (cpu_pc == bp);
`else
    assign is_halt  = (cmd_op == OP_HALT);
`endif

    assign cmd_ready = (state == S_IDLE) || ((state == S_RUN) && is_halt);
    assign halt_acc  = (state == S_RUN) && cmd_valid && is_halt;
    assign wd_hit    = (cnt == RUN_MAX);

`ifdef DBG_BREAKPOINT_EN
    assign run_exit  = cpu_stop || halt_acc || bp_hit || wd_hit;
`else
    assign run_exit  = cpu_stop || halt_acc || wd_hit;
`endif
    assign step_exit = cpu_stop || (cnt == STEP_CYC);

    // The exit cycle must already see cpu_ce low, so the registered enable
    // is gated by the same-cycle exit condition.
    assign cpu_ce = ce_en && (((state == S_RUN) && !run_exit) ||
                              ((state == S_STEP) && !step_exit));

    always_comb begin
        run_rsp = {2'b11, cpu_pc[29:0]};
        if (cpu_stop)
            run_rsp = {2'b01, cpu_pc[29:0]};
        else if (halt_acc)
            run_rsp = {2'b10, cpu_pc[29:0]};
`ifdef DBG_BREAKPOINT_EN
        else if (bp_hit)
            run_rsp = {2'b11, cpu_pc[29:0]};
        else
            run_rsp = {1'b1, 1'b0, cpu_pc[29:0]};  // watchdog: bit 31 flag, status 0
`endif
    end

    assign step_rsp = {(cpu_stop ? 2'b01 : 2'b00), cpu_pc[29:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            cnt       <= '0;
            ce_en     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            inst_we   <= 1'b0;
            data_we   <= 1'b0;
            rf_dcp_rd <= 1'b0;
            inst_addr <= '0;
            data_addr <= '0;
            rf_addr   <= '0;
            inst_in   <= '0;
            data_in   <= '0;
`ifdef DBG_BREAKPOINT_EN
            bp        <= '0;
            bp_armed  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    op_q <= cmd_op;
                    case (cmd_op)
                        OP_WR_INST: begin
                            inst_we   <= 1'b1;
                            inst_addr <= cmd_addr;
                            inst_in   <= cmd_data;
                            state     <= S_WRITE;
                        end
                        OP_WR_DATA: begin
                            data_we   <= 1'b1;
                            data_addr <= cmd_addr;
                            data_in   <= cmd_data;
                            state     <= S_WRITE;
                        end
                        OP_RD_INST: begin
                            inst_addr <= cmd_addr;
                            state     <= S_READ;
                        end
                        OP_RD_DATA: begin
                            data_addr <= cmd_addr;
                            state     <= S_READ;
                        end
                        OP_RD_RF: begin
                            rf_addr   <= cmd_addr[4:0];
                            rf_dcp_rd <= 1'b1;
                            state     <= S_READ;
                        end
                        OP_RUN: begin
                            cnt   <= '0;
                            ce_en <= 1'b1;
                            state <= S_RUN;
                        end
                        OP_STEP: begin
                            cnt   <= '0;
                            ce_en <= 1'b1;
                            state <= S_STEP;
                        end
                        default: begin
`ifdef DBG_BREAKPOINT_EN
                            if (is_setbp) begin
                                bp       <= cmd_data;
                                bp_armed <= 1'b1;
                                rsp_data <= ACK;
                            end else begin
                                rsp_data <= {2'b00, cpu_pc[29:0]};
                            end
`else
                            rsp_data <= {2'b00, cpu_pc[29:0]};
`endif
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end
                    endcase
                end
                S_WRITE: begin
                    inst_we   <= 1'b0;
                    data_we   <= 1'b0;
                    rsp_data  <= ACK;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_READ: begin
                    rf_dcp_rd <= 1'b0;
                    case (op_q)
                        OP_RD_INST: rsp_data <= inst_out;
                        OP_RD_DATA: rsp_data <= data_out;
                        default:    rsp_data <= rf_out;
                    endcase
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                S_RUN: begin
                    if (run_exit) begin
                        ce_en     <= 1'b0;
                        rsp_data  <= run_rsp;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
`ifdef DBG_BREAKPOINT_EN
                        if (bp_hit)
                            bp_armed <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_STEP: begin
                    if (step_exit) begin
                        ce_en     <= 1'b0;
                        rsp_data  <= step_rsp;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{cpu_pc[31:30], cmd_addr};

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Scoreboard bench for dbg_run_ctrl driving a toy ADDI-only core model.
module tb_dbg_run_ctrl;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_data;
    logic          cpu_ce;
    logic          cpu_stop;
    logic [31:0]   cpu_pc;
    logic          inst_we, data_we, rf_dcp_rd;
    logic [AW-1:0] inst_addr, data_addr;
    logic [4:0]    rf_addr;
    logic [31:0]   inst_in, data_in, inst_out, data_out, rf_out;

    always #5 clk = ~clk;

    dbg_run_ctrl #(.ADDR_W(AW), .STEP_CYC(5), .RUN_MAX(32'd64)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .cpu_ce(cpu_ce), .cpu_stop(cpu_stop), .cpu_pc(cpu_pc),
        .inst_we(inst_we), .data_we(data_we), .rf_dcp_rd(rf_dcp_rd),
        .inst_addr(inst_addr), .data_addr(data_addr), .rf_addr(rf_addr),
        .inst_in(inst_in), .data_in(data_in),
        .inst_out(inst_out), .data_out(data_out), .rf_out(rf_out)
    );

    // Toy core: memories, register file, and one ADDI per enabled cycle.
    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];
    logic [31:0] rf   [0:31];
    logic [31:0] pc, ce_total, cur_ins, stop_at;
    logic        stop_en = 1'b0;
    int          we_hi = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i] <= '0;
            dmem[i] <= '0;
        end
        for (int i = 0; i < 32; i++) rf[i] <= '0;
        stop_at <= '0;
    end

    assign cur_ins  = imem[pc[9:2]];
    assign cpu_pc   = pc;
    assign cpu_stop = stop_en && (ce_total == stop_at);
    assign inst_out = imem[inst_addr];
    assign data_out = dmem[data_addr];
    assign rf_out   = rf[rf_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= '0;
            ce_total <= '0;
        end else if (cpu_ce) begin
            pc       <= pc + 32'd4;
            ce_total <= ce_total + 32'd1;
        end
    end

    always @(posedge clk) begin
        if (inst_we) imem[inst_addr] <= inst_in;
        if (data_we) dmem[data_addr] <= data_in;
        if (inst_we) we_hi <= we_hi + 1;
        if (cpu_ce && cur_ins[6:0] == 7'h13 && cur_ins[14:12] == 3'd0 && cur_ins[11:7] != 5'd0)
            rf[cur_ins[11:7]] <= rf[cur_ins[19:15]] + {{20{cur_ins[31]}}, cur_ins[31:20]};
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct { string tag; logic [31:0] v; } exp_t;
    exp_t exp_q[$];

    task automatic expect_rsp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] st(input logic [1:0] s, input logic [31:0] p);
        return {s, p[29:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            check("rsp_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.tag, rsp_data, e.v);
            end
        end
        if (cpu_ce)
            check("strobe_while_ce", {29'd0, inst_we, data_we, rf_dcp_rd}, 32'd0);
    end

    task automatic send(input logic [2:0] op, input logic [7:0] addr, input logic [31:0] data);
        bit ok = 1'b0;
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("cmd_accept", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        int i = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && i < 300) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] p, s;
        int w;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        check("rst_strobes", {29'd0, inst_we, data_we, rf_dcp_rd}, 32'd0);
        check("rst_inst_addr", 32'(inst_addr), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a write
        send(3'd0, 8'h03, 32'h1234_5678);
        check("wr_strobe_on", 32'(inst_we), 32'd1);
        #2 rst = 1'b1;
        #1 check("rst_we_drop", 32'(inst_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_ce", 32'(cpu_ce), 32'd0);
        check("post_rst_nowrite", imem[3], 32'd0);

        // Instruction write then read-back with latency check
        w = we_hi;
        expect_rsp("wr_inst_ack", 32'd1);
        send(3'd0, 8'h04, 32'h0050_0093);
        drain();
        check("we_pulse_len", 32'(we_hi - w), 32'd1);
        expect_rsp("rd_inst", 32'h0050_0093);
        send(3'd2, 8'h04, 32'd0);
        @(negedge clk);
        check("rd_lat_cyc1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("rd_lat_cyc2", 32'(rsp_valid), 32'd1);
        drain();

        // Data memory at the top address
        expect_rsp("wr_data_ack", 32'd1);
        send(3'd1, 8'hFF, 32'hDEAD_BEEF);
        expect_rsp("rd_data_top", 32'hDEAD_BEEF);
        send(3'd3, 8'hFF, 32'd0);
        drain();

        // Load ADDI and single-step
        expect_rsp("wr_prog_ack", 32'd1);
        send(3'd0, 8'h00, 32'h0050_0093);
        drain();
        p = pc; s = ce_total;
        expect_rsp("step_rsp", st(2'b00, p + 32'd20));
        send(3'd6, 8'h00, 32'd0);
        drain();
        check("step_ce_cycles", ce_total - s, 32'd5);
        expect_rsp("rd_rf_x1", 32'd5);
        send(3'd4, 8'h01, 32'd0);
        drain();

        // HALT while idle
        p = pc;
        expect_rsp("halt_idle", st(2'b00, p));
        send(3'd7, 8'h00, 32'd0);
        drain();
        check("halt_idle_pc", pc, p);

        // RUN ended by cpu_stop after 20 cycles
        p = pc; s = ce_total;
        stop_at = s + 32'd20; stop_en = 1'b1;
        expect_rsp("run_stop", st(2'b01, p + 32'd80));
        send(3'd5, 8'h00, 32'd0);
        cmd_op = 3'd0;
        @(negedge clk);
        check("run_ready_wr", 32'(cmd_ready), 32'd0);
        cmd_op = 3'd4;
        @(negedge clk);
        check("run_ready_rdrf", 32'(cmd_ready), 32'd0);
        cmd_op = 3'd7;
        @(negedge clk);
        check("run_ready_halt", 32'(cmd_ready), 32'd1);
        cmd_op = 3'd0;
        drain();
        stop_en = 1'b0;
        check("run_stop_ce", ce_total - s, 32'd20);

        // RUN ended by HALT in cycle 10, response held with rsp_ready low
        p = pc; s = ce_total;
        expect_rsp("run_halt", st(2'b10, p + 32'd40));
        send(3'd5, 8'h00, 32'd0);
        rsp_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        send(3'd7, 8'h00, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", rsp_data, st(2'b10, p + 32'd40));
            check("hold_ce", 32'(cpu_ce), 32'd0);
        end
        rsp_ready = 1'b1;
        drain();
        check("run_halt_ce", ce_total - s, 32'd10);

        // Watchdog at RUN_MAX
        p = pc; s = ce_total;
`ifdef DBG_BREAKPOINT_EN
        expect_rsp("run_wdog", st(2'b10, p + 32'd256));
`else
        expect_rsp("run_wdog", st(2'b11, p + 32'd256));
`endif
        send(3'd5, 8'h00, 32'd0);
        drain();
        check("run_wdog_ce", ce_total - s, 32'd64);

        // STEP cut short by cpu_stop
        p = pc; s = ce_total;
        stop_at = s + 32'd2; stop_en = 1'b1;
        expect_rsp("step_stop", st(2'b01, p + 32'd8));
        send(3'd6, 8'h00, 32'd0);
        drain();
        stop_en = 1'b0;
        check("step_stop_ce", ce_total - s, 32'd2);

`ifdef DBG_BREAKPOINT_EN
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        expect_rsp("setbp_ack", 32'd1);
        send(3'd7, 8'h80, 32'h0000_0010);
        expect_rsp("run_bp", st(2'b11, 32'h10));
        send(3'd5, 8'h00, 32'd0);
        drain();
        check("bp_pc", pc, 32'h10);
        s = ce_total;
        stop_at = s + 32'd10; stop_en = 1'b1;
        expect_rsp("run_bp_disarmed", st(2'b01, 32'h10 + 32'd40));
        send(3'd5, 8'h00, 32'd0);
        drain();
        stop_en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dbg_run_ctrl.md
Name: dbg_run_ctrl

Overview:
- Debug/run sequencer sitting between the host command channel (UART decoder or testbench) and the pipelined CPU core.
- Owns the core's debug load/read ports (inst_we, data_we, rf_dcp_rd, address/data buses) and its clock enable.
- Serialises host commands: write/read instruction memory, data memory and the register file; run, single-step and halt the core.
- Guarantees the core never executes while debug writes are in flight.

Parameters:
- ADDR_W, 8, word address width of inst/data memories.
- STEP_CYC, 5, core clock-enable cycles per STEP command (drains the 5-stage pipeline).
- RUN_MAX, 32'hFFFF_FFFF, watchdog limit on RUN cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  block accepts a command this cycle.
- cmd_op  in  3  0 WR_INST, 1 WR_DATA, 2 RD_INST, 3 RD_DATA, 4 RD_RF, 5 RUN, 6 STEP, 7 HALT.
- cmd_addr  in  ADDR_W  word address (RD_RF uses [4:0]).
- cmd_data  in  32  write data.
- rsp_valid  out  1  response word valid.
- rsp_ready  in  1  host takes the response.
- rsp_data  out  32  read data or status.
- cpu_ce  out  1  core clock enable.
- cpu_stop  in  1  core halt/ecall indication.
- cpu_pc  in  32  core PC, for status and breakpoint.
- inst_we, data_we, rf_dcp_rd  out  1  debug strobes to the core.
- inst_addr, data_addr  out  ADDR_W  debug addresses.
- rf_addr  out  5  debug register-file address.
- inst_in, data_in  out  32  debug write data.
- inst_out, data_out, rf_out  in  32  core debug read data (combinational).

Behaviour:
- Reset (async, rst=1): state IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; cpu_ce=0; all strobes 0; address/data outputs 0; cycle counter 0.
- Reset mid-operation aborts any write, read, RUN or STEP immediately; no partial strobe survives reset.
- Handshake:
  - Command accepted on cmd_valid&cmd_ready.
  - cmd_ready=1 only in IDLE, or in RUN when cmd_op==HALT.
  - Response held stable until rsp_valid&rsp_ready.
- States:
  - IDLE: accept command. WR_* -> WRITE; RD_* -> READ; RUN -> RUN; STEP -> STEP; HALT -> RESP with status.
  - WRITE: one cycle.
    - inst_we or data_we=1; addr/data driven from the registered command.
    - Next state RESP with rsp_data=32'h0000_0001 (ack).
  - READ: one cycle.
    - Drive address (rf_dcp_rd=1 for RD_RF).
    - Register inst_out/data_out/rf_out into rsp_data at end of cycle; next RESP.
    - Read latency, accept to rsp_valid: 2 cycles.
  - RESP: rsp_valid=1; to IDLE on rsp_ready.
  - RUN: cpu_ce=1 every cycle; counter increments.
    - Exit to RESP on the first of: cpu_stop=1 (status 1), HALT accepted (status 2), counter==RUN_MAX (status 3).
    - Exit cycle has cpu_ce=0.
    - rsp_data = {status[1:0], cpu_pc[29:0]} sampled at the exit cycle.
  - STEP: cpu_ce=1 for exactly STEP_CYC cycles, then RESP with status 0 and PC.
    - cpu_stop during STEP ends it early with status 1.
- cpu_ce=0 in every state except RUN and STEP; debug strobes never asserted while cpu_ce=1.
- HALT in IDLE returns status 0 with current PC, no side effects.
- Counter is 32-bit, cleared on RUN entry; no wrap (bounded by RUN_MAX).
- Simultaneous cpu_stop and HALT in the same RUN cycle: cpu_stop wins (status 1).

Optional Feature:
- Macro DBG_BREAKPOINT_EN.
- Enabled:
  - cmd_op 7 with cmd_addr[7]=1 is SET_BP: stores cmd_data as the breakpoint PC and arms it; response is ack.
  - RUN exits with status 3 when cpu_pc==bp and armed; bp then auto-disarms.
  - Watchdog status moves to rsp_data bit 31 set with status 0.
- Disabled: op 7 is always HALT; no breakpoint register or comparator is synthesised.

Test Plan:
- Reset mid-WRITE: assert rst in the WRITE cycle -> inst_we falls immediately; cmd_ready=1, rsp_valid=0, cpu_ce=0 after release.
- WR_INST addr 8'h04, data 32'h00500093, then RD_INST 8'h04 -> inst_we pulses exactly 1 cycle; read rsp_data=32'h00500093 two cycles after accept.
- Load addi program, STEP -> cpu_ce high exactly 5 cycles; RD_RF addr 1 returns 32'h5.
- RUN with cpu_stop forced at cycle 20 -> cpu_ce high 20 cycles; rsp_data[31:30]=2'b01; cmd_ready stays 0 for non-HALT ops during RUN.
- RUN then HALT at cycle 10, with rsp_ready held low 3 cycles -> status 2'b10; rsp_data stable until rsp_ready; cpu_ce=0 from the exit cycle onward.
- DBG_BREAKPOINT_EN: SET_BP 32'h0000_0010 then RUN -> exit when cpu_pc==0x10 with status 3; second RUN is not stopped by the breakpoint.
